// File: rtl/hilo_unit_if.sv
// Request bus from decode into the HI/LO unit.
// Carries op_valid/op_ready handshake, op_code and src_a/src_b operands.
interface hilo_unit_if;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;

  modport master (
    output op_valid, op_code, src_a, src_b,
    input  op_ready
  );

  modport slave (
    input  op_valid, op_code, src_a, src_b,
    output op_ready
  );
endinterface

// File: rtl/hilo_unit.sv
// Multiply/divide issue stage and HI/LO owner: feeds the external multiplier,
// runs a restoring divider, exposes hi/lo, busy, done, div_zero.
module hilo_unit #(
  parameter int MUL_LAT = 1
) (
  input  logic        mul_clk,
  input  logic        reset,
  hilo_unit_if.slave  req,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  output logic        mul_signed,
  input  logic [63:0] mul_result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_hi, r_lo;
  logic [31:0] r_mx, r_my;
  logic        r_ms;
  logic        r_done, r_dz;
  logic [31:0] r_dvd, r_dvs, r_rem;
  logic        r_qneg, r_rneg, r_zero;

  logic        w_acc;
  logic        w_mul, w_div, w_mthi, w_mtlo;
  logic        w_sgn;
  logic [31:0] w_a_abs, w_b_abs;
  logic [32:0] w_rem, w_diff;
  logic        w_ge;

  assign req.op_ready = (r_state == S_IDLE) && !reset;
  assign w_acc = req.op_valid && req.op_ready;

  assign w_mul  = req.op_code[2:1] == 2'b00;
  assign w_div  = req.op_code[2:1] == 2'b01;
  assign w_mthi = req.op_code == 3'b100;
  assign w_mtlo = req.op_code == 3'b101;
  assign w_sgn  = !req.op_code[0];

  assign w_a_abs = (w_sgn && req.src_a[31]) ? -req.src_a : req.src_a;
  assign w_b_abs = (w_sgn && req.src_b[31]) ? -req.src_b : req.src_b;

  // Shift next dividend bit into the remainder; the borrow of the trial
  // subtraction decides the quotient bit.
  assign w_rem  = {r_rem, r_dvd[31]};
  assign w_diff = w_rem - {1'b0, r_dvs};
  assign w_ge   = !w_diff[32];

  always_ff @(posedge mul_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mx    <= '0;
      r_my    <= '0;
      r_ms    <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            unique case (1'b1)
              w_mul: begin
                r_mx    <= req.src_a;
                r_my    <= req.src_b;
                r_ms    <= w_sgn;
                r_cnt   <= 6'(MUL_LAT);
                r_state <= S_MUL;
              end
              w_div: begin
                if (req.src_b == '0) begin
                  r_zero  <= 1'b1;
                  r_state <= S_FIX;
                end else begin
                  r_zero  <= 1'b0;
                  r_dvd   <= w_a_abs;
                  r_dvs   <= w_b_abs;
                  r_qneg  <= w_sgn && (req.src_a[31] ^ req.src_b[31]);
                  r_rneg  <= w_sgn && req.src_a[31];
                  r_rem   <= '0;
                  r_cnt   <= 6'd32;
                  r_state <= S_DIV;
                end
              end
              w_mthi: begin
                r_hi   <= req.src_a;
                r_done <= 1'b1;
              end
              w_mtlo: begin
                r_lo   <= req.src_a;
                r_done <= 1'b1;
              end
              default: r_done <= 1'b1;
            endcase
          end
        end
        S_MUL: begin
          if (r_cnt == '0) begin
            {r_hi, r_lo} <= mul_result;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        S_DIV: begin
          r_rem <= w_ge ? w_diff[31:0] : w_rem[31:0];
          r_dvd <= {r_dvd[30:0], w_ge};
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) r_state <= S_FIX;
        end
        default: begin
          if (r_zero) begin
            r_dz <= 1'b1;
          end else begin
            r_lo <= r_qneg ? -r_dvd : r_dvd;
            r_hi <= r_rneg ? -r_rem : r_rem;
          end
          r_zero  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mul_x      = r_mx;
  assign mul_y      = r_my;
  assign mul_signed = r_ms;
  assign hi         = r_hi;
  assign lo         = r_lo;
  assign busy       = r_state != S_IDLE;
  assign done       = r_done;
  assign div_zero   = r_dz;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with a one-register multiplier model.
// Covers MUL/DIV/MTHI/MTLO latency, edge cases, divide-by-zero and reset.
module tb_hilo_unit;
  logic        clk;
  logic        reset;
  logic [31:0] mul_x, mul_y;
  logic        mul_signed;
  logic [63:0] mul_result;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;
  int          n_chk;
  int          n_err;

  hilo_unit_if bus ();

  hilo_unit #(.MUL_LAT(1)) dut (
    .mul_clk    (clk),
    .reset      (reset),
    .req        (bus.slave),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_signed (mul_signed),
    .mul_result (mul_result),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mul_signed)
      mul_result <= {{32{mul_x[31]}}, mul_x} * {{32{mul_y[31]}}, mul_y};
    else
      mul_result <= {32'd0, mul_x} * {32'd0, mul_y};
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = c;
    bus.src_a    = a;
    bus.src_b    = b;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    mul_result = '0;
    bus.op_valid = 1'b0;
    bus.op_code  = 3'd0;
    bus.src_a    = '0;
    bus.src_b    = '0;
    reset = 1'b1;
    step(3);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mx", 64'(mul_x), 64'd0);
    chk("rst_ms", 64'(mul_signed), 64'd0);
    chk("rst_rdy", 64'(bus.op_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rdy1", 64'(bus.op_ready), 64'd1);

    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mu_busy0", 64'(busy), 64'd1);
    chk("mu_done0", 64'(done), 64'd0);
    step(1);
    chk("mu_busy1", 64'(busy), 64'd1);
    chk("mu_done1", 64'(done), 64'd0);
    step(1);
    chk("mu_done2", 64'(done), 64'd1);
    chk("mu_busy2", 64'(busy), 64'd0);
    chk("mu_rdy2", 64'(bus.op_ready), 64'd1);
    chk("mu_hi", 64'(hi), 64'hFFFFFFFE);
    chk("mu_lo", 64'(lo), 64'h00000001);
    step(1);
    chk("mu_done3", 64'(done), 64'd0);

    issue(3'b000, 32'hFFFFFFFE, 32'd3);
    chk("ms_sgn", 64'(mul_signed), 64'd1);
    step(2);
    chk("ms_done", 64'(done), 64'd1);
    chk("ms_hi", 64'(hi), 64'hFFFFFFFF);
    chk("ms_lo", 64'(lo), 64'hFFFFFFFA);

    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    chk("dv_busy", 64'(busy), 64'd1);
    step(32);
    chk("dv_done32", 64'(done), 64'd0);
    chk("dv_busy32", 64'(busy), 64'd1);
    step(1);
    chk("dv_done33", 64'(done), 64'd1);
    chk("dv_lo", 64'(lo), 64'hFFFFFFFD);
    chk("dv_hi", 64'(hi), 64'hFFFFFFFF);
    chk("dv_dz", 64'(div_zero), 64'd0);

    issue(3'b011, 32'd100, 32'd7);
    step(33);
    chk("du_done", 64'(done), 64'd1);
    chk("du_lo", 64'(lo), 64'd14);
    chk("du_hi", 64'(hi), 64'd2);

    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    step(33);
    chk("dmin_lo", 64'(lo), 64'h80000000);
    chk("dmin_hi", 64'(hi), 64'd0);

    issue(3'b100, 32'hDEADBEEF, 32'd0);
    chk("mthi_hi", 64'(hi), 64'hDEADBEEF);
    chk("mthi_done", 64'(done), 64'd1);
    chk("mthi_rdy", 64'(bus.op_ready), 64'd1);
    chk("mthi_busy", 64'(busy), 64'd0);
    issue(3'b101, 32'h12345678, 32'd0);
    chk("mtlo_lo", 64'(lo), 64'h12345678);
    chk("mtlo_hi", 64'(hi), 64'hDEADBEEF);
    chk("mtlo_done", 64'(done), 64'd1);
    chk("mtlo_rdy", 64'(bus.op_ready), 64'd1);

    issue(3'b100, 32'h11, 32'd0);
    issue(3'b101, 32'h22, 32'd0);
    issue(3'b011, 32'd5, 32'd0);
    chk("dz_busy", 64'(busy), 64'd1);
    chk("dz_done0", 64'(done), 64'd0);
    step(1);
    chk("dz_done", 64'(done), 64'd1);
    chk("dz_flag", 64'(div_zero), 64'd1);
    chk("dz_hi", 64'(hi), 64'h11);
    chk("dz_lo", 64'(lo), 64'h22);
    step(1);
    chk("dz_flag2", 64'(div_zero), 64'd0);

    issue(3'b010, 32'd100, 32'd3);
    step(9);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_hi", 64'(hi), 64'd0);
    chk("mr_lo", 64'(lo), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_done", 64'(done), 64'd0);
    chk("mr_rdy0", 64'(bus.op_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mr_rdy1", 64'(bus.op_ready), 64'd1);
    for (int i = 0; i < 30; i++) begin
      step(1);
      chk("mr_nodone", 64'(done), 64'd0);
    end
    issue(3'b001, 32'd3, 32'd4);
    step(2);
    chk("mr_mu_done", 64'(done), 64'd1);
    chk("mr_mu_lo", 64'(lo), 64'd12);
    chk("mr_mu_hi", 64'(hi), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/hilo_unit.md
# hilo_unit

Multiply/divide issue stage and HI/LO register owner for the CPU datapath. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO one at a time from decode, drives operands into the Booth/Wallace `multipler` and captures its registered 64-bit result, and runs a 32-iteration restoring divider internally. HI/LO live here and are read combinationally by the MFHI/MFLO path.

## Interface

Parameters:
- MUL_LAT, 1: rising edges from operands reaching the multiplier inputs to a valid `mul_result`. The multiplier registers once, so this is 1.

Ports:
- mul_clk, in, 1: sole clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high.
- op_valid, in, 1: request valid.
- op_ready, out, 1: unit can accept a request.
- op_code, in, 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. Codes 110 and 111 are accepted as no-ops that complete like MTHI without writing.
- src_a, in, 32: rs operand (dividend, multiplicand, or MTHI/MTLO data).
- src_b, in, 32: rt operand (divisor or multiplier).
- mul_x, out, 32: operand to the multiplier (registered).
- mul_y, out, 32: operand to the multiplier (registered).
- mul_signed, out, 1: signed-mode select to the multiplier (registered).
- mul_result, in, 64: multiplier output.
- hi, out, 32: HI register.
- lo, out, 32: LO register.
- busy, out, 1: a multi-cycle operation is in flight.
- done, out, 1: one-cycle pulse, high in the first cycle HI/LO reflect the completed operation.
- div_zero, out, 1: pulses with `done` when DIV/DIVU has src_b == 0.

## Operation

- Handshake: a request is accepted on an edge where op_valid && op_ready. op_ready = (state == IDLE) && !reset. Inputs are ignored when not accepted.
- States: IDLE, MUL_WAIT, DIV_RUN, DIV_FIX.
- IDLE, MTHI/MTLO accepted: the target register is written at the accept edge and the unit stays in IDLE. done is high for the next cycle; busy stays 0.
- IDLE, MULT/MULTU accepted: mul_x/mul_y/mul_signed are loaded, a counter is loaded with MUL_LAT, and the unit enters MUL_WAIT.
- MUL_WAIT: the counter decrements each edge. On the edge after it reaches 0, {hi,lo} <= mul_result and the unit returns to IDLE.
- IDLE, DIV/DIVU accepted:
  - If src_b == 0, go to DIV_FIX with the zero flag set.
  - Otherwise latch |a|, |b| (magnitudes for DIV, raw values for DIVU) and the sign flags qneg = a[31]^b[31] and rneg = a[31] (both 0 for DIVU). Clear the 33-bit partial remainder, set the iteration count to 32, and go to DIV_RUN.
- DIV_RUN, one quotient bit per edge, MSB first:
  - rem' = {rem[31:0], dividend_msb}, then shift the dividend left.
  - If rem' >= {1'b0, |b|}: subtract and shift in quotient bit 1; otherwise keep rem' and shift in 0.
  - After the 32nd iteration, go to DIV_FIX.
- DIV_FIX (one edge):
  - Normal case: lo <= qneg ? -q : q and hi <= rneg ? -r : r (two's complement, 32-bit wrap), then return to IDLE.
  - Zero flag set: hi/lo unchanged and div_zero pulses with done.
- Width and edge rules:
  - DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. No trap.
  - The remainder sign always follows the dividend.
- busy = (state != IDLE).

## Timing

- Reset values: hi = 0, lo = 0, mul_x = 0, mul_y = 0, mul_signed = 0, busy = 0, done = 0, div_zero = 0, state = IDLE. op_ready is 0 while reset is high and 1 in the first cycle after it deasserts.
- Reset mid-operation: on the next edge the unit returns to IDLE with all reset values. The in-flight result is discarded, no done pulse is produced, and a late mul_result is ignored.
- Latency, counted from the accept edge E0:
  - MTHI/MTLO: HI/LO updated at E0; done is high in the cycle after E0.
  - MULT/MULTU: HI/LO written at E0+MUL_LAT+1 (E2 at the default); done is high in the cycle after E2.
  - DIV/DIVU: HI/LO written at E33; done is high in the cycle after E33.
  - Divide by zero: done and div_zero are high in the cycle after E1.
- Back-to-back: op_ready is high again in the same cycle done is high, so a new request can be accepted at that edge. Peak throughput is one MTHI/MTLO per cycle.
- hi and lo are direct register outputs with no bypass. A read in the cycle where done is high sees the new value.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF accepted at E0 → done is high in the cycle after E2; hi = 0xFFFFFFFE, lo = 0x00000001; busy = 1 during MUL_WAIT only.
- MULT 0xFFFFFFFE (−2) × 3 → hi = 0xFFFFFFFF, lo = 0xFFFFFFFA; mul_signed = 1 while the operation is in flight.
- DIV −7 / 2 → lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFF (−1); done is high in the cycle after E33. Also DIVU 100 / 7 → lo = 14, hi = 2.
- DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0. DIVU 5 / 0 with hi = 0x11, lo = 0x22 preloaded via MTHI/MTLO → done and div_zero are high in the cycle after E1; hi/lo unchanged.
- MTHI 0xDEADBEEF at E0, then MTLO 0x12345678 at E1 → hi updated at E0 and lo at E1; op_ready stays 1 throughout; done is high in the cycles after E0 and E1.
- Assert reset at iteration 10 of a DIV → after that edge hi = lo = 0, busy = 0, and no done pulse. op_ready goes high in the first cycle after reset deasserts, and a new MULTU 3 × 4 then gives lo = 12.
